div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential restoring divider, one quotient bit per cycle.
//                Signed (div) and unsigned (divu) modes, divide-by-zero
//                short path, pipeline annul, {remainder, quotient} result.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 whilo_o,
    output logic                 stallreq_o
);

    localparam int            c_CW       = $clog2(WIDTH) + 1;
    localparam logic [1:0]    c_ST_FREE  = 2'd0;
    localparam logic [1:0]    c_ST_BYZ   = 2'd1;
    localparam logic [1:0]    c_ST_ON    = 2'd2;
    localparam logic [1:0]    c_ST_END   = 2'd3;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);

    logic [1:0]          r_state;
    logic [c_CW-1:0]     r_cnt;
    logic [WIDTH-1:0]    r_dvd;      // dividend magnitude, shifts out MSB first, quotient shifts in at LSB
    logic [WIDTH-1:0]    r_dvs;      // divisor magnitude
    logic [WIDTH-1:0]    r_rem;      // partial remainder
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*WIDTH-1:0]  r_result;
    logic                r_ready;

    logic                w_neg_a;
    logic                w_neg_b;
    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic [WIDTH:0]      w_rem_sh;
    logic                w_ge;
    logic [WIDTH-1:0]    w_rem_nxt;
    logic [WIDTH-1:0]    w_quo_nxt;
    logic [WIDTH-1:0]    w_quo_fix;
    logic [WIDTH-1:0]    w_rem_fix;

    // Operand magnitudes and sign flags at acceptance time.
    always_comb begin
        w_neg_a = signed_div_i & opdata1_i[WIDTH-1];
        w_neg_b = signed_div_i & opdata2_i[WIDTH-1];
        w_mag_a = w_neg_a ? -opdata1_i : opdata1_i;
        w_mag_b = w_neg_b ? -opdata2_i : opdata2_i;
    end

    // One restoring step; the remainder needs one extra bit before the compare,
    // but after a successful subtract it always fits back into WIDTH bits.
    always_comb begin
        w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_dvs});
        w_rem_nxt = w_rem_sh[WIDTH-1:0] - (w_ge ? r_dvs : '0);
        w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};
        w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
        w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    end

    // Divider state machine with registered result and ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_FREE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FREE: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= c_ST_BYZ;
                        end else begin
                            r_state <= c_ST_ON;
                            r_dvd   <= w_mag_a;
                            r_dvs   <= w_mag_b;
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                        end
                    end
                end
                c_ST_BYZ: begin
                    r_result <= '0;
                    if (annul_i) begin
                        r_state <= c_ST_FREE;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= c_ST_END;
                        r_ready <= 1'b1;
                    end
                end
                c_ST_ON: begin
                    if (annul_i) begin
                        r_state  <= c_ST_FREE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_quo_nxt;
                        r_cnt <= r_cnt + c_CW'(1);
                        if (r_cnt == c_CNT_LAST) begin
                            r_state  <= c_ST_END;
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // End state: hold the result while the requester keeps start high.
                    if (annul_i || !start_i) begin
                        r_state  <= c_ST_FREE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
            endcase
        end
    end

    // Stall the pipeline from acceptance until the result is available; never during reset.
    always_comb begin
        stallreq_o = rst & (((r_state == c_ST_FREE) & start_i & ~annul_i) |
                            (r_state == c_ST_BYZ) | (r_state == c_ST_ON));
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign whilo_o  = r_ready;

endmodule
`default_nettype wire
